// File: rtl/fp_add_sub_pipe.sv
// Pipelined IEEE-754 adder/subtractor: unpack/align, add, normalise, round/pack.
// Round-to-nearest-even, subnormals flushed to zero, valid/ready flow control.
module fp_add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int EXP_W  = 8,
  parameter int MANT_W = WIDTH - EXP_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_invalid,
  output logic             flag_overflow,
  output logic             flag_inexact
);

  localparam int AL_W  = MANT_W + 4;  // hidden, fraction, G, R, S
  localparam int SUM_W = MANT_W + 5;  // plus carry
  localparam int XE_W  = EXP_W + 2;   // two's-complement working exponent
  localparam int LZ_W  = $clog2(AL_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MANT_W + 3);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  function automatic logic [LZ_W-1:0] lzc(input logic [AL_W-1:0] v);
    logic found;
    lzc   = {LZ_W{1'b0}};
    found = 1'b0;
    for (int i = AL_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + LZ_W'(1);
      end
    end
  endfunction

  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic [EXP_W-1:0]  w_a_exp, w_b_exp, w_l_exp, w_s_exp, w_diff;
  logic              w_a_sign, w_b_sign, w_a_zero, w_b_zero, w_swap, w_lost;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_byp, w_byp_inv;
  logic [MANT_W:0]   w_a_mant, w_b_mant, w_l_mant, w_s_mant;
  logic [WIDTH-2:0]  w_a_mag, w_b_mag;
  logic [AL_W-1:0]   w_ext, w_aligned, w_s_al;
  logic [WIDTH-1:0]  w_byp_res;

  assign w_a_sign = a[WIDTH-1];
  assign w_b_sign = b[WIDTH-1] ^ operation_select;
  assign w_a_exp  = a[WIDTH-2:MANT_W];
  assign w_b_exp  = b[WIDTH-2:MANT_W];
  assign w_a_zero = (w_a_exp == {EXP_W{1'b0}});
  assign w_b_zero = (w_b_exp == {EXP_W{1'b0}});
  assign w_a_nan  = (w_a_exp == EXP_ONES) && (a[MANT_W-1:0] != {MANT_W{1'b0}});
  assign w_b_nan  = (w_b_exp == EXP_ONES) && (b[MANT_W-1:0] != {MANT_W{1'b0}});
  assign w_a_inf  = (w_a_exp == EXP_ONES) && (a[MANT_W-1:0] == {MANT_W{1'b0}});
  assign w_b_inf  = (w_b_exp == EXP_ONES) && (b[MANT_W-1:0] == {MANT_W{1'b0}});
  assign w_a_mant = w_a_zero ? {(MANT_W+1){1'b0}} : {1'b1, a[MANT_W-1:0]};
  assign w_b_mant = w_b_zero ? {(MANT_W+1){1'b0}} : {1'b1, b[MANT_W-1:0]};
  // Subnormals compare as zero so the flushed operand always ends up smaller
  assign w_a_mag  = w_a_zero ? {(WIDTH-1){1'b0}} : a[WIDTH-2:0];
  assign w_b_mag  = w_b_zero ? {(WIDTH-1){1'b0}} : b[WIDTH-2:0];
  assign w_swap   = (w_b_mag > w_a_mag);
  assign w_l_exp  = w_swap ? w_b_exp  : w_a_exp;
  assign w_s_exp  = w_swap ? w_a_exp  : w_b_exp;
  assign w_l_mant = w_swap ? w_b_mant : w_a_mant;
  assign w_s_mant = w_swap ? w_a_mant : w_b_mant;
  assign w_diff   = w_l_exp - w_s_exp;
  assign w_ext    = {w_s_mant, 3'b000};

  assign w_byp     = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
  assign w_byp_inv = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign));
  assign w_byp_res = w_byp_inv ? QNAN
                   : {(w_a_inf ? w_a_sign : w_b_sign), EXP_ONES, {MANT_W{1'b0}}};

  // Right-shift the smaller mantissa, folding shifted-out bits into sticky
  always_comb begin
    w_aligned = {AL_W{1'b0}};
    w_lost    = 1'b0;
    if (w_diff >= SHIFT_MAX) begin
      w_aligned = {{(AL_W-1){1'b0}}, |w_s_mant};
      w_lost    = 1'b0;
    end else begin
      w_aligned = w_ext >> w_diff;
      w_lost    = |(w_ext & ~({AL_W{1'b1}} << w_diff));
    end
  end
  assign w_s_al = {w_aligned[AL_W-1:1], w_aligned[0] | w_lost};

  logic              r1_valid, r1_sign, r1_sub, r1_byp, r1_byp_inv;
  logic [EXP_W-1:0]  r1_exp;
  logic [MANT_W:0]   r1_mant_l;
  logic [AL_W-1:0]   r1_mant_s;
  logic [WIDTH-1:0]  r1_byp_res;

  // ---------------- S2: magnitude add/subtract ----------------
  logic [SUM_W-1:0]  w_sum;
  assign w_sum = r1_sub ? ({1'b0, r1_mant_l, 3'b000} - {1'b0, r1_mant_s})
                        : ({1'b0, r1_mant_l, 3'b000} + {1'b0, r1_mant_s});

  logic              r2_valid, r2_sign, r2_byp, r2_byp_inv;
  logic [EXP_W-1:0]  r2_exp;
  logic [SUM_W-1:0]  r2_sum;
  logic [WIDTH-1:0]  r2_byp_res;

  // ---------------- S3a: normalise ----------------
  logic [LZ_W-1:0]   w_lz;
  logic [AL_W-1:0]   w_norm;
  logic [XE_W-1:0]   w_nexp;
  assign w_lz = lzc(r2_sum[AL_W-1:0]);

  // Carry-out shifts right keeping sticky; otherwise shift out leading zeros
  always_comb begin
    w_norm = {AL_W{1'b0}};
    w_nexp = {XE_W{1'b0}};
    if (r2_sum[SUM_W-1]) begin
      w_norm = {r2_sum[SUM_W-1:2], r2_sum[1] | r2_sum[0]};
      w_nexp = {2'b00, r2_exp} + XE_W'(1);
    end else begin
      w_norm = r2_sum[AL_W-1:0] << w_lz;
      w_nexp = {2'b00, r2_exp} - XE_W'(w_lz);
    end
  end

  logic              r3_valid, r3_sign, r3_zero, r3_byp, r3_byp_inv;
  logic [XE_W-1:0]   r3_exp;
  logic [AL_W-1:0]   r3_norm;
  logic [WIDTH-1:0]  r3_byp_res;

  // ---------------- S3b: round and pack ----------------
  logic              w_rnd_up, w_grs, w_ovf_cond, w_unf_cond;
  logic [MANT_W+1:0] w_rmant;
  logic [XE_W-1:0]   w_rexp;
  logic [MANT_W-1:0] w_rfrac;
  logic [WIDTH-1:0]  w_res;
  logic              w_inv, w_ovf, w_inx;

  assign w_grs      = |r3_norm[2:0];
  assign w_rnd_up   = r3_norm[2] && (r3_norm[1] || r3_norm[0] || r3_norm[3]);
  assign w_rmant    = {1'b0, r3_norm[AL_W-1:3]} + {{(MANT_W+1){1'b0}}, w_rnd_up};
  assign w_rexp     = r3_exp + {{(XE_W-1){1'b0}}, w_rmant[MANT_W+1]};
  assign w_rfrac    = w_rmant[MANT_W+1] ? w_rmant[MANT_W:1] : w_rmant[MANT_W-1:0];
  assign w_ovf_cond = !w_rexp[XE_W-1] && (w_rexp[XE_W-2:0] >= {1'b0, EXP_ONES});
  assign w_unf_cond = w_rexp[XE_W-1] || (w_rexp == {XE_W{1'b0}});

  // Final result selection: bypass, exact zero, overflow, underflow, normal
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_inv = 1'b0;
    w_ovf = 1'b0;
    w_inx = 1'b0;
    if (r3_byp) begin
      w_res = r3_byp_res;
      w_inv = r3_byp_inv;
    end else if (r3_zero) begin
      w_res = {r3_sign, {(WIDTH-1){1'b0}}};
    end else if (w_ovf_cond) begin
      w_res = {r3_sign, EXP_ONES, {MANT_W{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_unf_cond) begin
      w_res = {r3_sign, {(WIDTH-1){1'b0}}};
      w_inx = 1'b1;
    end else begin
      w_res = {r3_sign, w_rexp[EXP_W-1:0], w_rfrac};
      w_inx = w_grs;
    end
  end

  logic             r_out_valid, r_inv, r_ovf, r_inx;
  logic [WIDTH-1:0] r_result;

  // Valid bits and output registers: the only reset state in the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_inv       <= 1'b0;
      r_ovf       <= 1'b0;
      r_inx       <= 1'b0;
    end else if (w_advance) begin
      r1_valid    <= in_valid;
      r2_valid    <= r1_valid;
      r3_valid    <= r2_valid;
      r_out_valid <= r3_valid;
      r_result    <= w_res;
      r_inv       <= w_inv;
      r_ovf       <= w_ovf;
      r_inx       <= w_inx;
    end
  end

  // Datapath stage registers, all advancing together
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r1_sign    <= w_swap ? w_b_sign : w_a_sign;
      r1_sub     <= w_a_sign ^ w_b_sign;
      r1_exp     <= w_l_exp;
      r1_mant_l  <= w_l_mant;
      r1_mant_s  <= w_s_al;
      r1_byp     <= w_byp;
      r1_byp_inv <= w_byp_inv;
      r1_byp_res <= w_byp_res;
      // An exact cancellation is +0; a same-sign zero sum keeps its sign
      r2_sign    <= (r1_sub && (w_sum == {SUM_W{1'b0}})) ? 1'b0 : r1_sign;
      r2_exp     <= r1_exp;
      r2_sum     <= w_sum;
      r2_byp     <= r1_byp;
      r2_byp_inv <= r1_byp_inv;
      r2_byp_res <= r1_byp_res;
      r3_sign    <= r2_sign;
      r3_zero    <= (r2_sum == {SUM_W{1'b0}});
      r3_exp     <= w_nexp;
      r3_norm    <= w_norm;
      r3_byp     <= r2_byp;
      r3_byp_inv <= r2_byp_inv;
      r3_byp_res <= r2_byp_res;
    end
  end

  assign out_valid     = r_out_valid;
  assign result        = r_result;
  assign flag_invalid  = r_inv;
  assign flag_overflow = r_ovf;
  assign flag_inexact  = r_inx;

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe: binary32 and binary16 instances,
// flags ordered {invalid, overflow, inexact}.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_ready;
  logic        op;
  logic        in_valid32, in_ready32, out_valid32;
  logic [31:0] a32, b32, result32;
  logic        inv32, ovf32, inx32;
  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] a16, b16, result16;
  logic        inv16, ovf16, inx16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_add_sub_pipe #(.WIDTH(32), .EXP_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .operation_select(op), .out_valid(out_valid32),
    .out_ready(out_ready), .result(result32), .flag_invalid(inv32),
    .flag_overflow(ovf32), .flag_inexact(inx32));

  fp_add_sub_pipe #(.WIDTH(16), .EXP_W(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .operation_select(op), .out_valid(out_valid16),
    .out_ready(out_ready), .result(result16), .flag_invalid(inv16),
    .flag_overflow(ovf16), .flag_inexact(inx16));

  task automatic run_op(input bit w16, input logic [31:0] av, input logic [31:0] bv,
                        input logic opv, input logic [31:0] exp_res,
                        input logic [2:0] exp_fl, input string name, output int edges);
    logic        got;
    logic [31:0] res;
    logic [2:0]  fl;
    @(negedge clk);
    out_ready  = 1'b1;
    a32 = av;  b32 = bv;  a16 = av[15:0];  b16 = bv[15:0];  op = opv;
    in_valid32 = !w16;
    in_valid16 = w16;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    in_valid16 = 1'b0;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      got = w16 ? out_valid16 : out_valid32;
    end
    res = w16 ? {16'h0000, result16} : result32;
    fl  = w16 ? {inv16, ovf16, inx16} : {inv32, ovf32, inx32};
    n_total++;
    if (!got)
      $display("FAIL %s: no out_valid within 20 cycles", name);
    else if (res !== exp_res || fl !== exp_fl)
      $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
               name, res, fl, exp_res, exp_fl);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if ({out_valid32, result32, inv32, ovf32, inx32, in_ready32} !== {1'b0, 32'h0, 4'b0001})
      $display("FAIL reset32: got ov=%b res=%h fl=%b%b%b rdy=%b, want 0/0/000/1",
               out_valid32, result32, inv32, ovf32, inx32, in_ready32);
    else n_pass++;
    n_total++;
    if ({out_valid16, result16, inv16, ovf16, inx16, in_ready16} !== {1'b0, 16'h0, 4'b0001})
      $display("FAIL reset16: got ov=%b res=%h fl=%b%b%b rdy=%b, want 0/0/000/1",
               out_valid16, result16, inv16, ovf16, inx16, in_ready16);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith32();
    int e;
    run_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "add_1p2", e);
    n_total++;
    if (e !== 3) $display("FAIL latency: got %0d edges, want 3", e);
    else n_pass++;
    run_op(1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "sub_zero", e);
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "neg0_add", e);
    run_op(1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, "neg0_sub", e);
    run_op(1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "rne_tie", e);
    run_op(1'b0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, "rne_up", e);
    run_op(1'b0, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, "underflow", e);
  endtask

  task automatic test_specials32();
    int e;
    run_op(1'b0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "inf_m_inf", e);
    run_op(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "overflow", e);
    run_op(1'b0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100, "nan_in", e);
    run_op(1'b0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, "fin_m_inf", e);
  endtask

  task automatic test_half();
    int e;
    run_op(1'b1, 32'h3C00, 32'h4000, 1'b0, 32'h4200, 3'b000, "h_add", e);
    run_op(1'b1, 32'h3C00, 32'h3C00, 1'b1, 32'h0000, 3'b000, "h_sub_zero", e);
    run_op(1'b1, 32'h3C00, 32'h1000, 1'b0, 32'h3C00, 3'b001, "h_rne_tie", e);
    run_op(1'b1, 32'h3C00, 32'h1001, 1'b0, 32'h3C01, 3'b001, "h_rne_up", e);
    run_op(1'b1, 32'h7C00, 32'hFC00, 1'b0, 32'h7E00, 3'b100, "h_inf_m_inf", e);
    run_op(1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b011, "h_overflow", e);
    run_op(1'b1, 32'h7C01, 32'h3C00, 1'b1, 32'h7E00, 3'b100, "h_nan_in", e);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[6], vb[6], ve[6];
    logic        vo[6];
    int idx  = 0;
    int ridx = 0;
    int cyc  = 0;
    logic acc;
    va[0] = 32'h3F800000; vb[0] = 32'h40000000; vo[0] = 1'b0; ve[0] = 32'h40400000;
    va[1] = 32'h40400000; vb[1] = 32'h3F800000; vo[1] = 1'b1; ve[1] = 32'h40000000;
    va[2] = 32'h40800000; vb[2] = 32'h40800000; vo[2] = 1'b0; ve[2] = 32'h41000000;
    va[3] = 32'hC0000000; vb[3] = 32'h3F800000; vo[3] = 1'b0; ve[3] = 32'hBF800000;
    va[4] = 32'h3F000000; vb[4] = 32'h3F000000; vo[4] = 1'b0; ve[4] = 32'h3F800000;
    va[5] = 32'h41200000; vb[5] = 32'h40A00000; vo[5] = 1'b1; ve[5] = 32'h40A00000;
    while (ridx < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready  = !(cyc >= 4 && cyc < 8);
      in_valid32 = (idx < 6);
      if (idx < 6) begin
        a32 = va[idx]; b32 = vb[idx]; op = vo[idx];
      end
      #1;
      n_total++;
      if (in_ready32 !== !(out_valid32 && !out_ready))
        $display("FAIL in_ready cyc%0d: got %b, want %b", cyc, in_ready32,
                 !(out_valid32 && !out_ready));
      else n_pass++;
      acc = in_valid32 && in_ready32;
      if (out_valid32 && out_ready) begin
        n_total++;
        if (result32 !== ve[ridx] || {inv32, ovf32, inx32} !== 3'b000)
          $display("FAIL b2b_res%0d: got %h flags=%b%b%b, want %h flags=000",
                   ridx, result32, inv32, ovf32, inx32, ve[ridx]);
        else n_pass++;
        ridx++;
      end
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid32 = 1'b0;
    out_ready  = 1'b1;
    n_total++;
    if (ridx !== 6) $display("FAIL b2b_count: got %0d results, want 6", ridx);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid32 !== 1'b0) $display("FAIL b2b_extra: got out_valid=%b, want 0", out_valid32);
      else n_pass++;
    end
  endtask

  task automatic test_reset_inflight();
    int e;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a32 = 32'h3F800000; b32 = 32'h40000000; op = 1'b0; in_valid32 = 1'b1;
      a16 = 16'h3C00;     b16 = 16'h4000;     in_valid16 = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (out_valid32 !== 1'b1) $display("FAIL pre_reset_valid: got %b, want 1", out_valid32);
    else n_pass++;
    in_valid32 = 1'b0;
    in_valid16 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid32, out_valid16, in_ready32} !== 3'b001)
      $display("FAIL reset_inflight: got ov32=%b ov16=%b rdy=%b, want 0 0 1",
               out_valid32, out_valid16, in_ready32);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid32, out_valid16} !== 2'b00)
        $display("FAIL post_reset_quiet: got ov32=%b ov16=%b, want 0 0", out_valid32, out_valid16);
      else n_pass++;
    end
    run_op(1'b0, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, "after_reset", e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; op = 1'b0;
    in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
    in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    test_reset();
    test_arith32();
    test_specials32();
    test_half();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
